// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NCORES cores.
// Optional MEM_ARB_LOCK_EN adds a per-core lock input for atomic read-modify-write.
module mem_bus_arbiter #(
   parameter int NCORES  = 4,
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int MEM_LAT = 2
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic [NCORES-1:0]           req,
   input  logic [NCORES-1:0]           we,
   input  logic [NCORES*AW-1:0]        addr,
   input  logic [NCORES*DW-1:0]        wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic [NCORES-1:0]           lock,
`endif
   output logic [AW-1:0]               mem_addr,
   output logic [DW-1:0]               mem_wdata,
   output logic                        mem_we,
   input  logic [DW-1:0]               mem_rdata,
   output logic [DW-1:0]               rdata,
   output logic [NCORES-1:0]           ack,
   output logic [((NCORES > 1) ? $clog2(NCORES) : 1)-1:0] gnt_id,
   output logic                        busy
);

   localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state, state_next;
   logic [GW-1:0]   last;
   logic [GW-1:0]   winner;
   logic            found;
   logic [CW-1:0]   cnt;
   int              probe;

`ifdef MEM_ARB_LOCK_EN
   logic            locked;
`endif

   // Rotating priority search starting just after the last granted core.
   always_comb begin
      winner = last;
      found  = 1'b0;
      probe  = 0;
      for (int o = 1; o <= NCORES; o++) begin
         probe = (int'(last) + o) % NCORES;
         if (!found && req[probe]) begin
            winner = GW'(probe);
            found  = 1'b1;
         end
      end
`ifdef MEM_ARB_LOCK_EN
      if (locked && req[gnt_id]) begin
         winner = gnt_id;
         found  = 1'b1;
      end
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = ACCESS;
         ACCESS:  if (cnt == CW'(1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         last      <= GW'(NCORES - 1);
         gnt_id    <= '0;
         cnt       <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         rdata     <= '0;
         ack       <= '0;
`ifdef MEM_ARB_LOCK_EN
         locked    <= 1'b0;
`endif
      end else begin
         state <= state_next;
         ack   <= '0;
         case (state)
            IDLE: begin
`ifdef MEM_ARB_LOCK_EN
               locked <= 1'b0;
`endif
               if (found) begin
                  gnt_id    <= winner;
                  last      <= winner;
                  mem_addr  <= addr[int'(winner)*AW +: AW];
                  mem_wdata <= wdata[int'(winner)*DW +: DW];
                  mem_we    <= we[winner];
                  cnt       <= CW'(MEM_LAT);
               end
            end
            ACCESS: begin
               // Write strobe lasts only the first access cycle; reads capture on the last one.
               mem_we <= 1'b0;
               cnt    <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  rdata       <= mem_rdata;
                  ack[gnt_id] <= 1'b1;
               end
            end
            DONE: begin
`ifdef MEM_ARB_LOCK_EN
               locked <= lock[gnt_id];
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
